// File: rtl/char_buffer_engine.sv
// rtl/char_buffer_engine.sv - character-cell buffer with pipelined renderer read port and clear/scroll-up engine
module char_buffer_engine #(
   parameter int COLS     = 80,
   parameter int ROWS     = 60,
   parameter int X_W      = 7,
   parameter int Y_W      = 6,
   parameter int ASCII_W  = 7,
   parameter int COLOUR_W = 6,
   parameter int ADDR_W   = 13
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [X_W-1:0]      i_wrx,
   input  logic [Y_W-1:0]      i_wry,
   input  logic                i_wren,
   input  logic [ASCII_W-1:0]  i_wascii,
   input  logic [COLOUR_W-1:0] i_wcolour,
   input  logic                i_whl,
   output logic                o_wready,
   input  logic [X_W-1:0]      i_rex,
   input  logic [Y_W-1:0]      i_rey,
   output logic [ASCII_W-1:0]  o_rascii,
   output logic [COLOUR_W-1:0] o_rcolour,
   output logic                o_rhighlight,
   input  logic                i_cmd_valid,
   input  logic [1:0]          i_cmd_op,
   input  logic [ASCII_W-1:0]  i_cmd_ascii,
   input  logic [COLOUR_W-1:0] i_cmd_colour,
   input  logic                i_cmd_hl,
   output logic                o_cmd_ready,
   output logic                o_busy,
   output logic                o_done
);

   localparam int N = COLS * ROWS;
   localparam int W = ASCII_W + COLOUR_W + 1;
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] COPY_END = ADDR_W'((ROWS - 1) * COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [X_W:0]      COLS_X   = (X_W + 1)'(COLS);
   localparam logic [Y_W:0]      ROWS_Y   = (Y_W + 1)'(ROWS);
   localparam logic [W-1:0]      OOB_CELL = {{ASCII_W{1'b0}}, {COLOUR_W{1'b1}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COPY, S_FILL, S_DONE} state_t;

   state_t r_state, w_next;

   // Two identical copies give the renderer and the engine independent read ports.
   logic [W-1:0] r_mem_rd [0:N-1];
   logic [W-1:0] r_mem_en [0:N-1];

   logic [W-1:0]      r_fill, r_eq, r_rq, r_out;
   logic [ADDR_W-1:0] r_src, r_dst, r_raddr;
   logic              r_first, r_roob0, r_roob1;

   logic              w_idle, w_cmd_acc, w_wr_oob, w_rd_oob, w_host_we, w_eng_we, w_we;
   logic [ADDR_W-1:0] w_wr_addr, w_rd_addr, w_waddr;
   logic [W-1:0]      w_eng_wdata, w_wdata;

   assign w_idle    = (r_state == S_IDLE);
   assign w_cmd_acc = i_cmd_valid & w_idle;
   assign w_wr_oob  = ({1'b0, i_wrx} >= COLS_X) || ({1'b0, i_wry} >= ROWS_Y);
   assign w_rd_oob  = ({1'b0, i_rex} >= COLS_X) || ({1'b0, i_rey} >= ROWS_Y);
   assign w_wr_addr = ADDR_W'(i_wry) * COLS_A + ADDR_W'(i_wrx);
   assign w_rd_addr = ADDR_W'(i_rey) * COLS_A + ADDR_W'(i_rex);
   assign w_host_we = i_wren & w_idle & ~w_wr_oob;

   always_comb begin
      w_next      = r_state;
      w_eng_we    = 1'b0;
      w_eng_wdata = r_fill;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_acc) begin
               case (i_cmd_op)
                  2'b00:   w_next = S_CLEAR;
                  2'b01:   w_next = S_COPY;
                  default: w_next = S_DONE;
               endcase
            end
         end
         S_CLEAR: begin
            w_eng_we = 1'b1;
            if (r_dst == LAST) w_next = S_DONE;
         end
         S_COPY: begin
            // The first COPY cycle only primes the engine read port.
            if (!r_first) begin
               w_eng_we    = 1'b1;
               w_eng_wdata = r_eq;
               if (r_dst == COPY_END) w_next = S_FILL;
            end
         end
         S_FILL: begin
            w_eng_we = 1'b1;
            if (r_dst == LAST) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_we    = w_eng_we | w_host_we;
   assign w_waddr = w_eng_we ? r_dst : w_wr_addr;
   assign w_wdata = w_eng_we ? w_eng_wdata : {i_wascii, i_wcolour, i_whl};

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
         r_src   <= '0;
         r_dst   <= '0;
         r_first <= 1'b0;
         r_raddr <= '0;
         r_roob0 <= 1'b0;
         r_roob1 <= 1'b0;
         r_out   <= '0;
      end else begin
         r_state <= w_next;
         if (w_cmd_acc) begin
            r_fill  <= {i_cmd_ascii, i_cmd_colour, i_cmd_hl};
            r_dst   <= '0;
            r_src   <= COLS_A;
            r_first <= 1'b1;
         end else begin
            case (r_state)
               S_CLEAR, S_FILL: if (r_dst != LAST) r_dst <= r_dst + 1'b1;
               S_COPY: begin
                  r_first <= 1'b0;
                  if (r_src != LAST) r_src <= r_src + 1'b1;
                  if (!r_first) r_dst <= r_dst + 1'b1;
               end
               default: ;
            endcase
         end
         r_raddr <= w_rd_oob ? '0 : w_rd_addr;
         r_roob0 <= w_rd_oob;
         r_roob1 <= r_roob0;
         r_out   <= r_roob1 ? OOB_CELL : r_rq;
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_we) begin
         r_mem_rd[w_waddr] <= w_wdata;
         r_mem_en[w_waddr] <= w_wdata;
      end
      r_rq <= r_mem_rd[r_raddr];
      r_eq <= r_mem_en[r_src];
   end

   assign o_rascii     = r_out[W-1 -: ASCII_W];
   assign o_rcolour    = r_out[COLOUR_W:1];
   assign o_rhighlight = r_out[0];
   assign o_wready     = w_idle;
   assign o_cmd_ready  = w_idle;
   assign o_busy       = (r_state == S_CLEAR) || (r_state == S_COPY) || (r_state == S_FILL);
   assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_char_buffer_engine.sv
// tb/tb_char_buffer_engine.sv - randomized directed bench for char_buffer_engine against an array reference model
module tb_char_buffer_engine;
   localparam int C = 80;
   localparam int R = 60;
   localparam int N = C * R;
   localparam logic [13:0] OOB_V = {7'd0, 6'h3F, 1'b1};

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] wrx, rex, cmd_ascii, wascii, rascii;
   logic [5:0] wry, rey, cmd_colour, wcolour, rcolour;
   logic       wren, whl, wready, rhighlight, cmd_valid, cmd_hl, cmd_ready, busy, done;
   logic [1:0] cmd_op;

   int checks = 0;
   int failures = 0;
   logic [13:0] model [N];
   logic [13:0] exp_q [$];

   char_buffer_engine dut (
      .i_clock(clk), .i_reset(rst),
      .i_wrx(wrx), .i_wry(wry), .i_wren(wren),
      .i_wascii(wascii), .i_wcolour(wcolour), .i_whl(whl), .o_wready(wready),
      .i_rex(rex), .i_rey(rey),
      .o_rascii(rascii), .o_rcolour(rcolour), .o_rhighlight(rhighlight),
      .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
      .i_cmd_ascii(cmd_ascii), .i_cmd_colour(cmd_colour), .i_cmd_hl(cmd_hl),
      .o_cmd_ready(cmd_ready), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] expect_cell(input int x, input int y);
      if (x >= C || y >= R) return OOB_V;
      return model[y * C + x];
   endfunction

   task automatic host_write(input int x, input int y, input logic [13:0] v);
      wrx = x[6:0];
      wry = y[5:0];
      {wascii, wcolour, whl} = v;
      wren = 1'b1;
      tick();
      wren = 1'b0;
      if (x < C && y < R) model[y * C + x] = v;
   endtask

   task automatic read_one(input int x, input int y, input string tag);
      rex = x[6:0];
      rey = y[5:0];
      tick(); tick(); tick();
      check(tag, {rascii, rcolour, rhighlight}, expect_cell(x, y));
   endtask

   // One read issued per cycle; each result is due three samples later.
   task automatic read_sweep(input int n, input bit seq, input string tag);
      int x, y;
      logic [13:0] e;
      exp_q.delete();
      for (int j = 0; j < n + 3; j++) begin
         if (j >= 3) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, j - 3), {rascii, rcolour, rhighlight}, e);
         end
         if (j < n) begin
            if (seq) begin
               x = j % C;
               y = j / C;
            end else begin
               x = $urandom_range(0, 90);
               y = $urandom_range(0, 63);
            end
            rex = x[6:0];
            rey = y[5:0];
            exp_q.push_back(expect_cell(x, y));
         end
         tick();
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [13:0] fill, input int exp_busy,
                          input bit traffic, input string tag);
      int busy_cnt, done_cnt, done_at;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      {cmd_ascii, cmd_colour, cmd_hl} = fill;
      check({tag, "_ready"}, cmd_ready, 1);
      tick();
      if (traffic) cmd_op = 2'b11;
      else cmd_valid = 1'b0;
      for (int cyc = 1; cyc <= exp_busy + 2; cyc++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = cyc;
         end
         if (traffic) begin
            if (cyc <= exp_busy) begin
               if (cyc == 1 || cyc == exp_busy || cyc % 97 == 0) begin
                  check($sformatf("%s_wready_busy@%0d", tag, cyc), wready, 0);
                  check($sformatf("%s_cmdready_busy@%0d", tag, cyc), cmd_ready, 0);
               end
               wrx = 7'($urandom_range(0, C - 1));
               wry = 6'($urandom_range(0, R - 1));
               {wascii, wcolour, whl} = 14'($urandom);
               wren = 1'b1;
            end else begin
               wren = 1'b0;
            end
            if (cyc == exp_busy + 1) check({tag, "_cmdready_done"}, cmd_ready, 0);
            if (cyc == exp_busy + 2) check({tag, "_cmdready_after"}, cmd_ready, 1);
         end
         tick();
      end
      if (traffic) begin
         check({tag, "_reaccept_done"}, done, 1);
         cmd_valid = 1'b0;
         tick();
      end
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_done_cycle"}, done_at, exp_busy + 1);
   endtask

   task automatic model_clear(input logic [13:0] fill);
      for (int i = 0; i < N; i++) model[i] = fill;
   endtask

   task automatic model_scroll(input logic [13:0] fill);
      for (int i = 0; i < N - C; i++) model[i] = model[i + C];
      for (int i = N - C; i < N; i++) model[i] = fill;
   endtask

   initial begin
      logic [13:0] f;
      rst = 1'b1;
      wrx = '0; wry = '0; wren = 1'b0; wascii = '0; wcolour = '0; whl = 1'b0;
      rex = '0; rey = '0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_ascii = '0; cmd_colour = '0; cmd_hl = 1'b0;
      tick(); tick();
      check("rst_rascii", rascii, 0);
      check("rst_rcolour", rcolour, 0);
      check("rst_rhl", rhighlight, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_wready", wready, 1);
      rst = 1'b0;
      tick();

      host_write(3, 2, {7'h41, 6'h2A, 1'b1});
      read_one(3, 2, "read_3_2");
      read_one(80, 0, "read_oob_x");
      read_one(5, 60, "read_oob_y");
      host_write(0, 59, {7'h55, 6'h11, 1'b0});
      host_write(0, 60, {7'h66, 6'h22, 1'b1});
      read_one(0, 59, "oob_write_dropped");

      run_cmd(2'b00, {7'h20, 6'h00, 1'b0}, N, 1'b0, "clear1");
      model_clear({7'h20, 6'h00, 1'b0});
      read_sweep(N, 1'b1, "clear1_cell");

      for (int i = 0; i < 400; i++)
         host_write($urandom_range(0, 90), $urandom_range(0, 63), 14'($urandom));
      read_sweep(300, 1'b0, "rand_read");

      f = 14'($urandom);
      run_cmd(2'b01, f, N + 1, 1'b1, "scroll1");
      model_scroll(f);
      read_sweep(N, 1'b1, "scroll1_cell");

      run_cmd(2'b10, 14'($urandom), 0, 1'b0, "reserved");
      read_sweep(200, 1'b0, "after_reserved");

      for (int i = 0; i < 100; i++)
         host_write($urandom_range(0, C - 1), $urandom_range(0, R - 1), 14'($urandom));
      cmd_valid = 1'b1;
      cmd_op = 2'b01;
      tick();
      cmd_valid = 1'b0;
      repeat (2000) tick();
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out", {rascii, rcolour, rhighlight}, 0);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_wready", wready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      f = 14'($urandom);
      run_cmd(2'b00, f, N, 1'b0, "clear2");
      model_clear(f);
      read_sweep(N, 1'b1, "clear2_cell");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/char_buffer_engine.md
# char_buffer_engine

Parametrised character-cell buffer for the text display path: stores ASCII, colour and highlight per cell, serves the VGA renderer through a pipelined read port, and adds a command engine that clears the screen or scrolls it up one row in hardware. It replaces the fixed 80x60/40x30 dual-bank buffer with one geometry chosen at elaboration. It sits between the active mode (host writes and commands) and the renderer (reads).

## Interface

Parameters:
- COLS, 80, cells per row.
- ROWS, 60, rows.
- X_W, 7, x coordinate width.
- Y_W, 6, y coordinate width.
- ASCII_W, 7, character code width.
- COLOUR_W, 6, colour width.
- ADDR_W, 13, cell address width; must be at least ceil(log2(COLS*ROWS)).

Ports:
- clock  in  1  the single clock for all logic and RAM.
- reset  in  1  asynchronous, active-high.
- wrx / wry  in  X_W / Y_W  host write coordinates.
- wren  in  1  host write strobe.
- wascii / wcolour / whl  in  ASCII_W / COLOUR_W / 1  host write data.
- wready  out  1  high when host writes are accepted (engine idle).
- rex / rey  in  X_W / Y_W  renderer read coordinates.
- rascii / rcolour / rhighlight  out  ASCII_W / COLOUR_W / 1  read data.
- cmd_valid  in  1  command request.
- cmd_op  in  2  00 clear, 01 scroll up, 10/11 reserved (accepted, no-op, done still pulses).
- cmd_ascii / cmd_colour / cmd_hl  in  ASCII_W / COLOUR_W / 1  fill cell for clear and scroll.
- cmd_ready  out  1  high in IDLE only.
- busy  out  1  engine running.
- done  out  1  one-cycle completion pulse.

## Operation

- Address = y*COLS + x. A coordinate is out of bounds (OOB) when x >= COLS or y >= ROWS.
- Storage: one write port plus two read ports, one for the renderer and one for the engine. It is built as two RAM copies written identically. Cell contents are not reset.
- Host write: a write lands when wren & wready & in-bounds. OOB writes and writes issued while busy are dropped silently.
- Renderer read: an OOB read returns ascii 0, colour all-ones, highlight 1. During a command, reads return whatever the RAM currently holds; tearing is acceptable.
- Command accept: cmd_valid & cmd_ready. On accept, cmd_op and the fill cell are captured.
- FSM states: IDLE, CLEAR, COPY, FILL, DONE.
  - IDLE -> CLEAR when op = 00.
  - IDLE -> COPY when op = 01.
  - IDLE -> DONE when op is reserved.
  - CLEAR: writes the fill cell to addresses 0..COLS*ROWS-1, one per cycle, then -> DONE.
  - COPY: the first cycle only reads source address COLS. Each later cycle writes the data read on the previous cycle to (source - COLS) and reads the next source. It performs (ROWS-1)*COLS writes, then -> FILL.
  - FILL: writes the fill cell to addresses (ROWS-1)*COLS..ROWS*COLS-1, then -> DONE.
  - DONE: done = 1 for one cycle, then -> IDLE.
- busy = 1 in CLEAR, COPY and FILL. wready = cmd_ready = (state == IDLE).
- Address counters are ADDR_W wide and never wrap past COLS*ROWS-1.

## Timing

- Reset values: rascii = 0, rcolour = 0, rhighlight = 0, busy = 0, done = 0, state = IDLE, so cmd_ready = wready = 1.
- Read latency is 2: coordinates sampled at edge k give valid outputs after edge k+2. The OOB flag is pipelined alongside the data.
- Host write at edge k is visible to a renderer read sampled at edge k+1 or later.
- Read-during-write to the same address returns the old data.
- Command accepted at edge t:
  - busy rises after edge t.
  - Clear: busy for COLS*ROWS cycles; done in cycle t+COLS*ROWS+1.
  - Scroll: busy for ROWS*COLS+1 cycles; done in cycle t+ROWS*COLS+2.
  - Reserved op: done in cycle t+1, with no busy.
- In the cycle a host write and a command accept coincide, both act: the write lands and the command starts next cycle.
- Reset mid-command: the command is abandoned, the FSM returns to IDLE, and RAM is left partially updated with no further writes.

## Test plan

- Defaults. Write (3,2) = 'A' (0x41), colour 0x2A, hl 1. Read (3,2) two cycles later -> 0x41 / 0x2A / 1. Read (80,0) -> 0x00 / 0x3F / 1.
- Write to (0,60) with wren = 1 -> RAM unchanged. Read (0,59) returns its prior value.
- Clear with fill 0x20 / 0x00 / 0. Busy is high for exactly 4800 cycles and done pulses once. Every cell then reads 0x20 / 0x00 / 0.
- COLS = 4, ROWS = 3. Preload cell value = address (0..11), then scroll with fill 0x7F. Done arrives 14 cycles after accept. Cells 0..7 read 4..11 and cells 8..11 read 0x7F.
- Issue host writes while busy -> dropped (wready = 0). Issue cmd_valid while busy -> not accepted until the cycle after done.
- Assert reset midway through a scroll. Busy, done and all outputs go to 0 immediately and cmd_ready = 1. A subsequent clear completes normally.
